// File: rtl/cpu_regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD registered read ports with
// optional write bypass, $fp/$sp taps and a per-register pending-write scoreboard.
module cpu_regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we0_i,
    input  logic [ADDR_W-1:0]          waddr0_i,
    input  logic [DATA_W-1:0]          wdata0_i,
    input  logic                       we1_i,
    input  logic [ADDR_W-1:0]          waddr1_i,
    input  logic [DATA_W-1:0]          wdata1_i,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
    output logic [NUM_RD*DATA_W-1:0]   rdata_o,
    output logic [NUM_RD-1:0]          rvalid_o,
    input  logic                       busy_set_i,
    input  logic [ADDR_W-1:0]          busy_idx_i,
    output logic [ADDR_W:0]            busy_cnt_o,
    output logic [DATA_W-1:0]          fp_o,
    output logic [DATA_W-1:0]          sp_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam bit          BYP   = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q  [DEPTH];
    logic [DATA_W-1:0] regs_d  [DEPTH];
    logic [DATA_W-1:0] rd_view [DEPTH];

    logic [DEPTH-1:0]          busy_q;
    logic [DEPTH-1:0]          busy_clr;
    logic [DEPTH-1:0]          busy_set;
    logic [DEPTH-1:0]          busy_after_clr;
    logic [DEPTH-1:0]          busy_d;
    logic [ADDR_W:0]           cnt_d;
    logic [NUM_RD*DATA_W-1:0]  rdata_d;
    logic [NUM_RD-1:0]         rvalid_d;

    // Port 1 is applied last so it wins a same-index collision.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (we0_i && (waddr0_i == i[ADDR_W-1:0])) regs_d[i] = wdata0_i;
            if (we1_i && (waddr1_i == i[ADDR_W-1:0])) regs_d[i] = wdata1_i;
            rd_view[i] = BYP ? regs_d[i] : regs_q[i];
        end
    end

    // Sets are applied after clears so a newer issue survives its own writeback edge.
    always_comb begin
        busy_clr = '0;
        busy_set = '0;
        if (we0_i)      busy_clr[waddr0_i]   = 1'b1;
        if (we1_i)      busy_clr[waddr1_i]   = 1'b1;
        if (busy_set_i) busy_set[busy_idx_i] = 1'b1;
        busy_after_clr = busy_q & ~busy_clr;
        busy_d         = busy_after_clr | busy_set;
        cnt_d          = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    // Validity ignores this edge's sets; without bypass a same-edge clear does not help.
    always_comb begin
        rdata_d  = '0;
        rvalid_d = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rdata_d[k*DATA_W +: DATA_W] = rd_view[raddr_i[k*ADDR_W +: ADDR_W]];
            rvalid_d[k] = BYP ? !busy_after_clr[raddr_i[k*ADDR_W +: ADDR_W]]
                              : !busy_q[raddr_i[k*ADDR_W +: ADDR_W]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_o <= '0;
            rdata_o    <= '0;
            rvalid_o   <= '1;
            fp_o       <= '0;
            sp_o       <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_o <= cnt_d;
            rdata_o    <= rdata_d;
            rvalid_o   <= rvalid_d;
            fp_o       <= rd_view[0];
            sp_o       <= rd_view[1];
        end
    end

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// Directed bench for cpu_regfile_mp: a bypassing and a non-bypassing instance
// share all inputs and are checked against hand-computed values.
module tb_cpu_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned NR = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0]   wa0 = '0, wa1 = '0;
    logic [DW-1:0]   wd0 = '0, wd1 = '0;
    logic [AW-1:0]   ra0 = '0, ra1 = '0;
    logic            bset = 1'b0;
    logic [AW-1:0]   bidx = '0;

    logic [NR*DW-1:0] rdata_b, rdata_n;
    logic [NR-1:0]    rvalid_b, rvalid_n;
    logic [AW:0]      cnt_b, cnt_n;
    logic [DW-1:0]    fp_b, sp_b, fp_n, sp_n;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .we0_i(we0), .waddr0_i(wa0), .wdata0_i(wd0),
        .we1_i(we1), .waddr1_i(wa1), .wdata1_i(wd1),
        .raddr_i({ra1, ra0}), .rdata_o(rdata_b), .rvalid_o(rvalid_b),
        .busy_set_i(bset), .busy_idx_i(bidx), .busy_cnt_o(cnt_b),
        .fp_o(fp_b), .sp_o(sp_b)
    );

    cpu_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) u_dut_nb (
        .clk_i(clk), .rst_ni(rst_n),
        .we0_i(we0), .waddr0_i(wa0), .wdata0_i(wd0),
        .we1_i(we1), .waddr1_i(wa1), .wdata1_i(wd1),
        .raddr_i({ra1, ra0}), .rdata_o(rdata_n), .rvalid_o(rvalid_n),
        .busy_set_i(bset), .busy_idx_i(bidx), .busy_cnt_o(cnt_n),
        .fp_o(fp_n), .sp_o(sp_n)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; bset = 1'b0;
    endtask

    initial begin
        // Reset state while held
        #12;
        chk("rst_rdata_b", rdata_b, 0);
        chk("rst_rvalid_b", rvalid_b, 2'b11);
        chk("rst_cnt_b", cnt_b, 0);
        chk("rst_rvalid_n", rvalid_n, 2'b11);
        rst_n = 1'b1;
        ra0 = 4'd3; ra1 = 4'd1;
        tick();
        chk("rel_rdata_b", rdata_b, 0);
        chk("rel_rvalid_b", rvalid_b, 2'b11);
        chk("rel_cnt_b", cnt_b, 0);
        chk("rel_fp_b", fp_b, 0);
        chk("rel_sp_b", sp_b, 0);

        // Write r5, same-edge read
        we0 = 1'b1; wa0 = 4'd5; wd0 = 32'hDEADBEEF; ra0 = 4'd5; ra1 = 4'd0;
        tick();
        chk("wr5_byp_b", rdata_b[31:0], 32'hDEADBEEF);
        chk("wr5_byp_n", rdata_n[31:0], 32'h0);
        idle();
        tick();
        chk("rd5_b", rdata_b[31:0], 32'hDEADBEEF);
        chk("rd5_n", rdata_n[31:0], 32'hDEADBEEF);

        // Same-index collision on r7, port 1 wins
        we0 = 1'b1; wa0 = 4'd7; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 4'd7; wd1 = 32'h22222222;
        ra0 = 4'd7; ra1 = 4'd5;
        tick();
        chk("col_byp_b", rdata_b[31:0], 32'h22222222);
        chk("col_byp_n", rdata_n[31:0], 32'h0);
        chk("col_rd1_b", rdata_b[63:32], 32'hDEADBEEF);
        idle();
        tick();
        chk("col_rd_n", rdata_n[31:0], 32'h22222222);
        chk("col_rd_b", rdata_b[31:0], 32'h22222222);

        // Scoreboard: mark r4 busy; the marking edge's read is still valid
        bset = 1'b1; bidx = 4'd4; ra0 = 4'd4; ra1 = 4'd7;
        tick();
        chk("bset_cnt_b", cnt_b, 1);
        chk("bset_cnt_n", cnt_n, 1);
        chk("bset_vld_b", rvalid_b, 2'b11);
        idle();
        tick();
        chk("busy_vld_b", rvalid_b, 2'b10);
        chk("busy_vld_n", rvalid_n, 2'b10);

        // Writeback r4 clears busy; bypass read is valid, non-bypass is stale
        we1 = 1'b1; wa1 = 4'd4; wd1 = 32'h40;
        tick();
        chk("wb_cnt_b", cnt_b, 0);
        chk("wb_rdata_b", rdata_b[31:0], 32'h40);
        chk("wb_vld_b", rvalid_b, 2'b11);
        chk("wb_rdata_n", rdata_n[31:0], 32'h0);
        chk("wb_vld_n", rvalid_n, 2'b10);
        idle();
        tick();
        chk("wb2_rdata_n", rdata_n[31:0], 32'h40);
        chk("wb2_vld_n", rvalid_n, 2'b11);

        // Set and clear of r4 on one edge: set wins
        bset = 1'b1; bidx = 4'd4; we0 = 1'b1; wa0 = 4'd4; wd0 = 32'h44;
        tick();
        chk("setclr_cnt_b", cnt_b, 1);
        chk("setclr_vld_b", rvalid_b, 2'b11);
        idle();
        // Re-setting an already busy bit, plus a second register
        bset = 1'b1; bidx = 4'd4;
        tick();
        chk("reset_cnt_b", cnt_b, 1);
        bidx = 4'd9;
        tick();
        chk("two_cnt_b", cnt_b, 2);
        idle();
        we0 = 1'b1; wa0 = 4'd4; wd0 = 32'h45;
        we1 = 1'b1; wa1 = 4'd9; wd1 = 32'h99;
        ra0 = 4'd9; ra1 = 4'd4;
        tick();
        chk("clr2_cnt_b", cnt_b, 0);
        chk("clr2_rdata_b", rdata_b, {32'h45, 32'h99});
        chk("clr2_vld_n", rvalid_n, 2'b00);
        idle();

        // fp/sp taps
        we0 = 1'b1; wa0 = 4'd0; wd0 = 32'h1000;
        we1 = 1'b1; wa1 = 4'd1; wd1 = 32'h2000;
        tick();
        chk("fp_b", fp_b, 32'h1000);
        chk("sp_b", sp_b, 32'h2000);
        chk("fp_n", fp_n, 32'h0);
        idle();
        tick();
        chk("fp2_n", fp_n, 32'h1000);
        chk("sp2_n", sp_n, 32'h2000);

        // Reset mid-operation
        bset = 1'b1; bidx = 4'd2;
        tick();
        bidx = 4'd3;
        tick();
        chk("pre_rst_cnt", cnt_b, 2);
        bset = 1'b0;
        we0 = 1'b1; wa0 = 4'd2; wd0 = 32'hAB; ra0 = 4'd2; ra1 = 4'd3;
        tick();
        chk("pre_rst_cnt2", cnt_b, 1);
        chk("pre_rst_rd", rdata_b[31:0], 32'hAB);
        chk("pre_rst_vld", rvalid_b, 2'b01);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata", rdata_b, 0);
        chk("mid_rst_fp", fp_b, 0);
        chk("mid_rst_sp", sp_b, 0);
        chk("mid_rst_cnt", cnt_b, 0);
        chk("mid_rst_vld", rvalid_b, 2'b11);
        rst_n = 1'b1;
        tick();
        chk("post_rst_rdata", rdata_b, 0);
        chk("post_rst_vld", rvalid_b, 2'b11);
        chk("post_rst_cnt", cnt_b, 0);
        chk("post_rst_rdata_n", rdata_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
